// File: rtl/video_pkg.sv
// Shared video timing defaults, coordinate types, rectangle FSM states and
// the host move-command payload used by the rectangle animator.
package video_pkg;

   localparam int unsigned H_ACTIVE_DEF = 320;
   localparam int unsigned V_ACTIVE_DEF = 480;
   localparam int unsigned COORD_W      = 16;
   localparam int unsigned DELTA_W      = 8;

   typedef logic signed [COORD_W-1:0] coord_t;
   typedef logic signed [DELTA_W-1:0] delta_t;

   typedef enum logic [1:0] {
      IDLE,
      CALC_X,
      CALC_Y,
      COMMIT
   } state_e;

   // Host move command as latched for the next frame edge.
   typedef struct packed {
      coord_t x;
      coord_t y;
      delta_t dx;
      delta_t dy;
   } move_cmd_t;

   // Clamp a coordinate into [0, hi].
   function automatic coord_t clamp_coord(input coord_t v, input coord_t hi);
      if (v < coord_t'(0)) return coord_t'(0);
      if (v > hi) return hi;
      return v;
   endfunction

endpackage

// File: rtl/rect_axis_step.sv
// One-axis bounce step: advances a position by its velocity and reflects the
// velocity off the [0, active-size] walls.
//   pos_i/d_i       current position and per-frame velocity
//   size_i/active_i rectangle extent and visible extent on this axis
//   pos_o/d_o       next position and velocity
module rect_axis_step
   import video_pkg::*;
(
   input  coord_t pos_i,
   input  delta_t d_i,
   input  coord_t size_i,
   input  coord_t active_i,
   output coord_t pos_o,
   output delta_t d_o
);

   localparam int unsigned SUM_W = 17;
   localparam logic signed [SUM_W-1:0] ZERO = '0;

   logic signed [SUM_W-1:0] sum_c;
   logic signed [SUM_W-1:0] max_c;
   delta_t                  abs_d_c;

   // Sized casts of signed operands sign-extend into the 17-bit sum.
   always_comb begin
      sum_c   = SUM_W'(pos_i) + SUM_W'(d_i);
      max_c   = SUM_W'(active_i) - SUM_W'(size_i);
      abs_d_c = d_i[DELTA_W-1] ? -d_i : d_i;
      pos_o   = pos_i;
      d_o     = d_i;
      // A stationary axis never moves or reverses.
      if (d_i != delta_t'(0)) begin
         if (sum_c <= ZERO) begin
            pos_o = coord_t'(0);
            d_o   = abs_d_c;
         end else if (sum_c >= max_c) begin
            pos_o = COORD_W'(max_c);
            d_o   = -abs_d_c;
         end else begin
            pos_o = COORD_W'(sum_c);
         end
      end
   end

endmodule

// File: rtl/rect_animator.sv
// Bouncing-rectangle animator: once per vsync rising edge it steps (or loads
// from a host command) the rectangle position, one axis per cycle through a
// shared axis stepper, and publishes new half-open bounds with a frame tick.
//   clk, reset           pixel clock, synchronous active-high reset
//   vsync, enable        frame sync input, motion enable
//   cmd_valid/cmd_ready  host load handshake with cmd_x/cmd_y/cmd_dx/cmd_dy
//   x0,x1,y0,y1          registered bounds [x0,x1) x [y0,y1)
//   frame_tick           one-cycle pulse when new bounds appear
//   frame_count          number of commits since reset
module rect_animator
   import video_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int RECT_W   = 32,
   parameter int RECT_H   = 32,
   parameter int INIT_X   = 0,
   parameter int INIT_Y   = 0,
   parameter int INIT_DX  = 1,
   parameter int INIT_DY  = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        vsync,
   input  logic        enable,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  coord_t      cmd_x,
   input  coord_t      cmd_y,
   input  delta_t      cmd_dx,
   input  delta_t      cmd_dy,
   output coord_t      x0,
   output coord_t      x1,
   output coord_t      y0,
   output coord_t      y1,
   output logic        frame_tick,
   output logic [15:0] frame_count
);

   localparam coord_t X_MAX = COORD_W'(H_ACTIVE - RECT_W);
   localparam coord_t Y_MAX = COORD_W'(V_ACTIVE - RECT_H);

   state_e      state_q;
   logic        vsync_q;
   coord_t      pos_x_q, pos_y_q;
   delta_t      dx_q, dy_q;
   move_cmd_t   load_q;
   logic        load_pending_q;
   coord_t      x0_q, x1_q, y0_q, y1_q;
   logic        frame_tick_q;
   logic [15:0] frame_count_q;

   logic        edge_c;
   logic        cmd_fire_c;
   logic        calc_y_c;
   coord_t      step_pos_c, step_size_c, step_active_c;
   delta_t      step_d_c;
   coord_t      pos_d;
   delta_t      d_d;

   assign edge_c     = vsync & ~vsync_q;
   assign cmd_ready  = (state_q == IDLE) && !edge_c;
   assign cmd_fire_c = cmd_valid & cmd_ready;

   // Steer the single axis stepper to whichever axis is being calculated.
   always_comb begin
      calc_y_c      = (state_q == CALC_Y);
      step_pos_c    = calc_y_c ? pos_y_q : pos_x_q;
      step_d_c      = calc_y_c ? dy_q : dx_q;
      step_size_c   = calc_y_c ? COORD_W'(RECT_H) : COORD_W'(RECT_W);
      step_active_c = calc_y_c ? COORD_W'(V_ACTIVE) : COORD_W'(H_ACTIVE);
   end

   rect_axis_step u_axis_step (
      .pos_i    (step_pos_c),
      .d_i      (step_d_c),
      .size_i   (step_size_c),
      .active_i (step_active_c),
      .pos_o    (pos_d),
      .d_o      (d_d)
   );

   // Frame FSM, command latch and registered bounds.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= IDLE;
         vsync_q        <= 1'b0;
         pos_x_q        <= COORD_W'(INIT_X);
         pos_y_q        <= COORD_W'(INIT_Y);
         dx_q           <= DELTA_W'(INIT_DX);
         dy_q           <= DELTA_W'(INIT_DY);
         load_q         <= '0;
         load_pending_q <= 1'b0;
         x0_q           <= COORD_W'(INIT_X);
         x1_q           <= COORD_W'(INIT_X + RECT_W);
         y0_q           <= COORD_W'(INIT_Y);
         y1_q           <= COORD_W'(INIT_Y + RECT_H);
         frame_tick_q   <= 1'b0;
         frame_count_q  <= '0;
      end else begin
         vsync_q      <= vsync;
         frame_tick_q <= 1'b0;
         if (cmd_fire_c) begin
            load_q <= '{x:  clamp_coord(cmd_x, X_MAX),
                        y:  clamp_coord(cmd_y, Y_MAX),
                        dx: cmd_dx,
                        dy: cmd_dy};
            load_pending_q <= 1'b1;
         end
         case (state_q)
            IDLE: begin
               if (edge_c) state_q <= CALC_X;
            end
            CALC_X: begin
               state_q <= CALC_Y;
               if (load_pending_q) begin
                  pos_x_q <= load_q.x;
                  dx_q    <= load_q.dx;
               end else if (enable) begin
                  pos_x_q <= pos_d;
                  dx_q    <= d_d;
               end
            end
            CALC_Y: begin
               state_q <= COMMIT;
               if (load_pending_q) begin
                  pos_y_q <= load_q.y;
                  dy_q    <= load_q.dy;
               end else if (enable) begin
                  pos_y_q <= pos_d;
                  dy_q    <= d_d;
               end
            end
            COMMIT: begin
               state_q        <= IDLE;
               x0_q           <= pos_x_q;
               x1_q           <= pos_x_q + COORD_W'(RECT_W);
               y0_q           <= pos_y_q;
               y1_q           <= pos_y_q + COORD_W'(RECT_H);
               frame_tick_q   <= 1'b1;
               frame_count_q  <= frame_count_q + 16'd1;
               load_pending_q <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign x0          = x0_q;
   assign x1          = x1_q;
   assign y0          = y0_q;
   assign y1          = y1_q;
   assign frame_tick  = frame_tick_q;
   assign frame_count = frame_count_q;

endmodule

// File: tb/tb_rect_animator.sv
// Directed self-checking bench for rect_animator with default parameters.
module tb_rect_animator;

   logic               clk;
   logic               reset;
   logic               vsync;
   logic               enable;
   logic               cmd_valid;
   logic               cmd_ready;
   logic signed [15:0] cmd_x, cmd_y;
   logic signed [7:0]  cmd_dx, cmd_dy;
   logic signed [15:0] x0, x1, y0, y1;
   logic               frame_tick;
   logic [15:0]        frame_count;

   int errors = 0;
   int checks = 0;

   rect_animator dut (
      .clk         (clk),
      .reset       (reset),
      .vsync       (vsync),
      .enable      (enable),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_x       (cmd_x),
      .cmd_y       (cmd_y),
      .cmd_dx      (cmd_dx),
      .cmd_dy      (cmd_dy),
      .x0          (x0),
      .x1          (x1),
      .y0          (y0),
      .y1          (y1),
      .frame_tick  (frame_tick),
      .frame_count (frame_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One-cycle vsync pulse; records frame_tick for the six following cycles.
   task automatic do_edge(output logic [5:0] hist);
      vsync = 1'b1;
      hist  = '0;
      for (int i = 0; i < 6; i++) begin
         step();
         hist[i] = frame_tick;
         if (i == 0) vsync = 1'b0;
      end
   endtask

   task automatic send_cmd(input int x, input int y, input int dx, input int dy);
      cmd_x     = 16'(x);
      cmd_y     = 16'(y);
      cmd_dx    = 8'(dx);
      cmd_dy    = 8'(dy);
      cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      checks++;
      if ({x0, x1, y0, y1} !== {16'sd0, 16'sd32, 16'sd0, 16'sd32}) begin
         errors++;
         $display("FAIL reset_bounds: got %0d %0d %0d %0d want 0 32 0 32", x0, x1, y0, y1);
      end
      checks++;
      if (frame_tick !== 1'b0) begin
         errors++;
         $display("FAIL reset_tick: got %b want 0", frame_tick);
      end
      checks++;
      if (frame_count !== 16'd0) begin
         errors++;
         $display("FAIL reset_count: got %0d want 0", frame_count);
      end
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: got %b want 1", cmd_ready);
      end
   endtask

   task automatic test_default_motion();
      logic [5:0] h;
      do_edge(h);
      checks++;
      if (h !== 6'b001000) begin
         errors++;
         $display("FAIL default_tick_timing: got %b want 001000", h);
      end
      checks++;
      if ({x0, x1, y0, y1} !== {16'sd1, 16'sd33, 16'sd1, 16'sd33}) begin
         errors++;
         $display("FAIL default_bounds: got %0d %0d %0d %0d want 1 33 1 33", x0, x1, y0, y1);
      end
      checks++;
      if (frame_count !== 16'd1) begin
         errors++;
         $display("FAIL default_count: got %0d want 1", frame_count);
      end
   endtask

   task automatic test_right_wall();
      logic [5:0] h;
      send_cmd(287, 100, 3, 0);
      checks++;
      if (x0 !== 16'sd1) begin
         errors++;
         $display("FAIL load_not_early: got x0=%0d want 1", x0);
      end
      do_edge(h);
      checks++;
      if ({x0, x1, y0, y1} !== {16'sd287, 16'sd319, 16'sd100, 16'sd132}) begin
         errors++;
         $display("FAIL load_bounds: got %0d %0d %0d %0d want 287 319 100 132", x0, x1, y0, y1);
      end
      do_edge(h);
      checks++;
      if ({x0, x1} !== {16'sd288, 16'sd320}) begin
         errors++;
         $display("FAIL right_wall_clamp: got x0=%0d x1=%0d want 288 320", x0, x1);
      end
      do_edge(h);
      checks++;
      if ({x0, y0} !== {16'sd285, 16'sd100}) begin
         errors++;
         $display("FAIL right_wall_reverse: got x0=%0d y0=%0d want 285 100", x0, y0);
      end
      checks++;
      if (frame_count !== 16'd4) begin
         errors++;
         $display("FAIL right_wall_count: got %0d want 4", frame_count);
      end
   endtask

   task automatic test_left_wall_and_clamp();
      logic [5:0] h;
      send_cmd(2, 100, -5, 0);
      do_edge(h);
      do_edge(h);
      checks++;
      if ({x0, x1} !== {16'sd0, 16'sd32}) begin
         errors++;
         $display("FAIL left_wall_clamp: got x0=%0d x1=%0d want 0 32", x0, x1);
      end
      do_edge(h);
      checks++;
      if (x0 !== 16'sd5) begin
         errors++;
         $display("FAIL left_wall_reverse: got x0=%0d want 5", x0);
      end
      send_cmd(-10, 1000, 0, 0);
      do_edge(h);
      checks++;
      if ({x0, x1, y0, y1} !== {16'sd0, 16'sd32, 16'sd448, 16'sd480}) begin
         errors++;
         $display("FAIL cmd_clamp: got %0d %0d %0d %0d want 0 32 448 480", x0, x1, y0, y1);
      end
      do_edge(h);
      checks++;
      if ({x0, y0} !== {16'sd0, 16'sd448}) begin
         errors++;
         $display("FAIL zero_velocity_hold: got x0=%0d y0=%0d want 0 448", x0, y0);
      end
      checks++;
      if (frame_count !== 16'd9) begin
         errors++;
         $display("FAIL left_wall_count: got %0d want 9", frame_count);
      end
   endtask

   task automatic test_enable_off();
      logic [5:0] h;
      int         ticks;
      send_cmd(50, 60, 2, -1);
      do_edge(h);
      enable = 1'b0;
      ticks  = 0;
      for (int e = 0; e < 3; e++) begin
         do_edge(h);
         for (int i = 0; i < 6; i++) ticks += int'(h[i]);
      end
      checks++;
      if (ticks !== 3) begin
         errors++;
         $display("FAIL disabled_ticks: got %0d want 3", ticks);
      end
      checks++;
      if ({x0, y0} !== {16'sd50, 16'sd60}) begin
         errors++;
         $display("FAIL disabled_hold: got x0=%0d y0=%0d want 50 60", x0, y0);
      end
      checks++;
      if (frame_count !== 16'd13) begin
         errors++;
         $display("FAIL disabled_count: got %0d want 13", frame_count);
      end
      enable = 1'b1;
      do_edge(h);
      checks++;
      if ({x0, y0} !== {16'sd52, 16'sd59}) begin
         errors++;
         $display("FAIL reenable_step: got x0=%0d y0=%0d want 52 59", x0, y0);
      end
   endtask

   task automatic test_cmd_handshake();
      logic [5:0] h;
      logic [3:0] rdy;
      cmd_x     = 16'sd10;
      cmd_y     = 16'sd20;
      cmd_dx    = 8'sd1;
      cmd_dy    = 8'sd1;
      cmd_valid = 1'b1;
      vsync     = 1'b1;
      #1;
      rdy[0] = cmd_ready;
      for (int i = 1; i < 4; i++) begin
         step();
         vsync  = 1'b0;
         rdy[i] = cmd_ready;
      end
      checks++;
      if (rdy !== 4'b0000) begin
         errors++;
         $display("FAIL busy_ready: got %b want 0000", rdy);
      end
      step();
      checks++;
      if ({cmd_ready, frame_tick} !== 2'b11) begin
         errors++;
         $display("FAIL idle_ready_tick: got ready=%b tick=%b want 1 1", cmd_ready, frame_tick);
      end
      checks++;
      if ({x0, y0} !== {16'sd54, 16'sd58}) begin
         errors++;
         $display("FAIL busy_no_load: got x0=%0d y0=%0d want 54 58", x0, y0);
      end
      step();
      cmd_valid = 1'b0;
      send_cmd(100, 200, -1, 2);
      do_edge(h);
      checks++;
      if ({x0, y0} !== {16'sd100, 16'sd200}) begin
         errors++;
         $display("FAIL second_cmd_wins: got x0=%0d y0=%0d want 100 200", x0, y0);
      end
      do_edge(h);
      checks++;
      if ({x0, y0} !== {16'sd99, 16'sd202}) begin
         errors++;
         $display("FAIL second_cmd_velocity: got x0=%0d y0=%0d want 99 202", x0, y0);
      end
      checks++;
      if (frame_count !== 16'd17) begin
         errors++;
         $display("FAIL handshake_count: got %0d want 17", frame_count);
      end
   endtask

   task automatic test_reset_mid_calc();
      logic [5:0] h;
      int         ticks;
      vsync = 1'b1;
      step();
      vsync = 1'b0;
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      ticks = int'(frame_tick);
      for (int i = 0; i < 4; i++) begin
         step();
         ticks += int'(frame_tick);
      end
      checks++;
      if ({x0, x1, y0, y1} !== {16'sd0, 16'sd32, 16'sd0, 16'sd32}) begin
         errors++;
         $display("FAIL abort_bounds: got %0d %0d %0d %0d want 0 32 0 32", x0, x1, y0, y1);
      end
      checks++;
      if (ticks !== 0) begin
         errors++;
         $display("FAIL abort_tick: got %0d pulses want 0", ticks);
      end
      checks++;
      if (frame_count !== 16'd0) begin
         errors++;
         $display("FAIL abort_count: got %0d want 0", frame_count);
      end
      force dut.frame_count_q = 16'hFFFF;
      #1;
      release dut.frame_count_q;
      do_edge(h);
      checks++;
      if (frame_count !== 16'd0) begin
         errors++;
         $display("FAIL count_wrap: got %0d want 0", frame_count);
      end
      checks++;
      if ({x0, y0, h} !== {16'sd1, 16'sd1, 6'b001000}) begin
         errors++;
         $display("FAIL post_abort_step: got x0=%0d y0=%0d tick=%b want 1 1 001000", x0, y0, h);
      end
   endtask

   initial begin
      reset     = 1'b1;
      vsync     = 1'b0;
      enable    = 1'b1;
      cmd_valid = 1'b0;
      cmd_x     = '0;
      cmd_y     = '0;
      cmd_dx    = '0;
      cmd_dy    = '0;
      test_reset();
      test_default_motion();
      test_right_wall();
      test_left_wall_and_clamp();
      test_enable_off();
      test_cmd_handshake();
      test_reset_mid_calc();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rect_animator.md
RECT_ANIMATOR -- requirements
Module: rect_animator

Interface
REQ-001 Parameter H_ACTIVE, default 320, visible pixels per line (half-horizontal 12 MHz timing).
REQ-002 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-003 Parameter RECT_W, default 32; RECT_H, default 32: rectangle size in pixels.
REQ-004 Parameters INIT_X 0, INIT_Y 0, INIT_DX 1, INIT_DY 1: reset position and velocity.
REQ-005 Ports SHALL be as follows; one clock; reset is synchronous and active-high:
  clk  in  1  pixel-domain clock (12 MHz)
  reset  in  1  synchronous, active-high reset
  vsync  in  1  vertical sync from sync generator, active-high
  enable  in  1  motion enable
  cmd_valid  in  1  host load request
  cmd_ready  out  1  load accepted when valid and ready are both high
  cmd_x, cmd_y  in  16 signed  new top-left position
  cmd_dx, cmd_dy  in  8 signed  new per-frame velocity
  x0, x1, y0, y1  out  16 signed  rectangle bounds for the drawing stage, half-open [x0,x1) x [y0,y1)
  frame_tick  out  1  one-cycle pulse when new bounds become visible
  frame_count  out  16  commits since reset, wraps 0xFFFF->0

Function
REQ-006 Frame edge SHALL be vsync high in this cycle (E) and low in the registered previous sample; the previous sample resets to 0.
REQ-007 FSM states IDLE, CALC_X, CALC_Y, COMMIT; an edge in IDLE moves to CALC_X at E+1, then CALC_Y at E+2 and COMMIT at E+3, and returns to IDLE at E+4.
REQ-008 Edges SHALL be ignored outside IDLE.
REQ-009 New x0/x1/y0/y1 SHALL be visible at E+4 and held constant until the next commit; frame_tick SHALL be high for exactly cycle E+4.
REQ-010 x1 SHALL equal x0+RECT_W and y1 SHALL equal y0+RECT_H at all times.
REQ-011 Per axis, CALC SHALL compute n = pos + sign-extended d in 17-bit signed arithmetic, with max = ACTIVE - SIZE.
REQ-012 If n <= 0, the axis SHALL set pos = 0 and d = |d|; if n >= max, it SHALL set pos = max and d = -|d|; otherwise pos = n and d is unchanged.
REQ-013 With d = 0, position SHALL stay unchanged and no reversal SHALL occur.
REQ-014 With enable low, CALC SHALL leave pos and d unchanged; commit, frame_tick and frame_count SHALL still occur.
REQ-015 cmd_ready SHALL be high only in IDLE with no edge in the current cycle.
REQ-016 An accepted command SHALL set load_pending and latch cmd_x clamped to [0, H_ACTIVE-RECT_W], cmd_y clamped to [0, V_ACTIVE-RECT_H], and cmd_dx/cmd_dy unchanged.
REQ-017 A later command accepted before the edge SHALL overwrite the latched values.
REQ-018 On an edge with load_pending set, CALC SHALL load the latched values instead of stepping, commit them, and clear load_pending at COMMIT.
REQ-019 frame_count SHALL increment at COMMIT.

Reset
REQ-020 On reset the FSM SHALL enter IDLE, clear load_pending and frame_count, and set frame_tick = 0.
REQ-021 On reset pos SHALL be INIT_X/INIT_Y, d SHALL be INIT_DX/INIT_DY, and outputs SHALL be x0 = INIT_X, x1 = INIT_X+RECT_W, y0 = INIT_Y, y1 = INIT_Y+RECT_H.
REQ-022 Reset asserted mid-calculation SHALL abandon the calculation; no partial commit SHALL become visible.
REQ-023 A vsync high at the cycle reset releases SHALL NOT count as an edge.

Structure
REQ-024 Shared package video_pkg SHALL hold H_ACTIVE/V_ACTIVE defaults, the coord_t signed-16 typedef and the FSM state enum.
REQ-025 Sub-module rect_axis_step (combinational pos/d/size/active -> next pos/d) SHALL be instantiated once and shared by CALC_X and CALC_Y.

Verification
REQ-026 Defaults, vsync rising edge at cycle E -> x0=1, x1=33, y0=1, y1=33 at E+4; frame_tick high only at E+4; frame_count=1.
REQ-027 Load cmd_x=287, dx=3 then one edge -> x0=288 (max), dx=-3; next edge -> x0=285.
REQ-028 Load cmd_x=2, dx=-5 then one edge -> x0=0, dx=+5; cmd_x=-10 -> clamped to 0; cmd_y=1000 -> clamped to 448.
REQ-029 enable=0 for 3 edges -> bounds unchanged, frame_tick 3 pulses, frame_count +3.
REQ-030 cmd_valid held during an edge cycle and CALC states -> cmd_ready low there, accepted only back in IDLE; two commands before an edge -> second wins.
REQ-031 reset asserted at E+2 -> bounds return to INIT values, no frame_tick; frame_count=0xFFFF plus one commit -> 0.
